sargantana_icache_refill_ctrl: RTL and testbench
================================================

SARGANTANA_ICACHE_REFILL_CTRL -- requirements
Module: sargantana_icache_refill_ctrl

Interface
REQ-001 SHALL have parameter NUM_WAYS, default 4, number of tag ways (power of 2, 2..8).
REQ-002 SHALL have parameter TAG_DEPTH, default 64, sets per way; TAG_ADDR_WIDHT = $clog2(TAG_DEPTH).
REQ-003 SHALL have parameter TAG_WIDHT, default 20, tag bits.
REQ-004 SHALL have ports, one per line:
 clk_i  in  1  single clock; all logic on posedge
 rst_i  in  1  synchronous, active-high reset
 miss_i  in  1  miss request, level, held until accepted
 miss_tag_i  in  TAG_WIDHT  missing tag
 miss_idx_i  in  TAG_ADDR_WIDHT  missing set index
 set_vbits_i  in  NUM_WAYS  valid bits of the indexed set, stable while miss_i high
 flush_i  in  1  cache flush, 1-cycle pulse
 busy_o  out  1  refill in progress; miss_i not accepted
 mem_req_valid_o  out  1  line-fetch request valid
 mem_req_ready_i  in  1  memory accepts request
 mem_req_addr_o  out  TAG_WIDHT+TAG_ADDR_WIDHT  {tag,idx} of line
 mem_rsp_valid_i  in  1  line returned, 1-cycle pulse
 mem_rsp_err_i  in  1  line returned with error, qualified by mem_rsp_valid_i
 tag_req_o  out  1  tag memory request
 tag_we_o  out  1  tag memory write enable
 tag_way_o  out  NUM_WAYS  one-hot way select
 tag_addr_o  out  TAG_ADDR_WIDHT  set index written
 tag_data_o  out  TAG_WIDHT  tag written
 tag_vbit_o  out  1  valid bit written
 refill_done_o  out  1  1-cycle pulse, refill finished (good or error)

Function
REQ-005 SHALL implement FSM states IDLE, REQ, WAIT, WRITE, DRAIN.
REQ-006 IDLE: miss_i=1 and flush_i=0 SHALL latch tag, idx and victim way, go to REQ next cycle; busy_o=1 from the following cycle.
REQ-007 REQ: mem_req_valid_o=1 with latched {tag,idx}; SHALL hold until mem_req_ready_i=1, then go to WAIT.
REQ-008 WAIT: mem_rsp_valid_i=1 SHALL go to WRITE; response arriving in the same cycle as the handshake is not allowed.
REQ-009 WRITE (exactly 1 cycle): tag_req_o=1, tag_we_o=1, tag_way_o=victim, tag_addr_o=idx, tag_data_o=tag, tag_vbit_o=!err; refill_done_o=1; next state IDLE.
REQ-010 Latency: miss accepted cycle N -> mem_req_valid_o at N+1; response cycle M -> tag write and refill_done_o at M+1.
REQ-011 Victim SHALL be the lowest-index way with set_vbits_i bit 0; if all valid, the replacement policy (REQ-019) selects it.
REQ-012 tag_req_o, tag_we_o SHALL be 0 outside WRITE; tag_way_o SHALL always be one-hot or zero.
REQ-013 flush_i in IDLE, REQ or WRITE SHALL abort to IDLE next cycle with no tag write and no refill_done_o; a REQ abort drops mem_req_valid_o even without ready.
REQ-014 flush_i in WAIT SHALL go to DRAIN; DRAIN discards the response, returns to IDLE after mem_rsp_valid_i, no tag write.
REQ-015 flush_i and miss_i together in IDLE: flush wins, miss not accepted.
REQ-016 miss_i while busy_o=1 SHALL be ignored (requester holds).

Reset
REQ-017 rst_i=1 SHALL force IDLE; busy_o, mem_req_valid_o, tag_req_o, tag_we_o, tag_vbit_o, refill_done_o = 0; tag_way_o, tag_addr_o, tag_data_o, mem_req_addr_o = 0; replacement state to seed.
REQ-018 Reset mid-refill SHALL abandon the refill; an in-flight response after reset is ignored in IDLE.

Configuration
REQ-019 Macro SARGANTANA_ICACHE_LFSR_REPL_EN defined: victim from 8-bit Fibonacci LFSR (taps 8,6,5,4, seed 8'h01), low log2(NUM_WAYS) bits, advancing once per WRITE; undefined: round-robin counter (reset 0), incremented once per WRITE.

Structure
REQ-020 sargantana_icache_pkg SHALL hold the FSM state enum, LFSR seed/taps and default NUM_WAYS/TAG_WIDHT/TAG_DEPTH constants.
REQ-021 Victim selection (invalid-first + LFSR/round-robin) SHALL be sub-module sargantana_icache_victim_sel.

Verification
REQ-022 Reset, set_vbits_i=4'b1011, miss tag 20'hABCDE idx 6'd5, ready at once, rsp 3 cycles later no err -> addr {20'hABCDE,6'd5}, WRITE way 4'b0100 vbit 1, refill_done_o 1 cycle.
REQ-023 set_vbits_i=4'b1111, macro undefined, three refills -> ways 0001,0010,0100; with macro, ways follow LFSR from seed 8'h01.
REQ-024 mem_rsp_err_i=1 on response -> WRITE with tag_vbit_o=0, refill_done_o=1.
REQ-025 flush_i in WAIT, rsp 2 cycles later -> DRAIN, no tag_req_o, no refill_done_o, busy_o low after rsp.
REQ-026 mem_req_ready_i low 5 cycles, rst_i mid-REQ -> mem_req_valid_o stable 5 cycles, then all outputs 0 next cycle, IDLE.

Source files
------------

// File: rtl/sargantana_icache_pkg.sv
// Shared constants, FSM state encoding and LFSR helper for the I-cache refill controller.
package sargantana_icache_pkg;

   localparam int unsigned DEF_NUM_WAYS  = 4;
   localparam int unsigned DEF_TAG_DEPTH = 64;
   localparam int unsigned DEF_TAG_WIDHT = 20;

   localparam logic [7:0] LFSR_SEED = 8'h01;
   // Taps 8,6,5,4 of the Fibonacci polynomial map to bit indices 7,5,4,3.
   localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_REQ   = 3'd1,
      ST_WAIT  = 3'd2,
      ST_WRITE = 3'd3,
      ST_DRAIN = 3'd4
   } refill_state_e;

   function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
      return {cur[6:0], ^(cur & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/sargantana_icache_victim_sel.sv
// Victim way selection: first invalid way, otherwise the replacement policy.
// SARGANTANA_ICACHE_LFSR_REPL_EN selects the LFSR policy; default is round-robin.
module sargantana_icache_victim_sel
   import sargantana_icache_pkg::*;
#(
   parameter int unsigned NUM_WAYS = DEF_NUM_WAYS
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [NUM_WAYS-1:0] vbits_i,
   input  logic                advance_i,
   output logic [NUM_WAYS-1:0] victim_o
);

   localparam int unsigned IDX_W = $clog2(NUM_WAYS);

   logic [IDX_W-1:0] repl_idx;
   logic             found;

`ifdef SARGANTANA_ICACHE_LFSR_REPL_EN
   logic [7:0] lfsr_q, lfsr_d;

   always_comb begin
      lfsr_d = lfsr_q;
      if (advance_i) lfsr_d = lfsr_next(lfsr_q);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) lfsr_q <= LFSR_SEED;
      else       lfsr_q <= lfsr_d;
   end

   assign repl_idx = lfsr_q[IDX_W-1:0];
`else
   logic [IDX_W-1:0] rr_q, rr_d;

   always_comb begin
      rr_d = rr_q;
      if (advance_i) rr_d = rr_q + IDX_W'(1);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) rr_q <= '0;
      else       rr_q <= rr_d;
   end

   assign repl_idx = rr_q;
`endif

   always_comb begin
      victim_o = '0;
      found    = 1'b0;
      for (int i = 0; i < NUM_WAYS; i++) begin
         if (!vbits_i[i] && !found) begin
            victim_o[i] = 1'b1;
            found       = 1'b1;
         end
      end
      if (!found) victim_o[repl_idx] = 1'b1;
   end

endmodule

// File: rtl/sargantana_icache_refill_ctrl.sv
// I-cache miss refill controller: line fetch request, response wait, tag write.
// Replacement policy set by SARGANTANA_ICACHE_LFSR_REPL_EN (see victim_sel).
module sargantana_icache_refill_ctrl
   import sargantana_icache_pkg::*;
#(
   parameter int unsigned NUM_WAYS       = DEF_NUM_WAYS,
   parameter int unsigned TAG_DEPTH      = DEF_TAG_DEPTH,
   parameter int unsigned TAG_WIDHT      = DEF_TAG_WIDHT,
   localparam int unsigned TAG_ADDR_WIDHT = $clog2(TAG_DEPTH)
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          miss_i,
   input  logic [TAG_WIDHT-1:0]          miss_tag_i,
   input  logic [TAG_ADDR_WIDHT-1:0]     miss_idx_i,
   input  logic [NUM_WAYS-1:0]           set_vbits_i,
   input  logic                          flush_i,
   output logic                          busy_o,
   output logic                          mem_req_valid_o,
   input  logic                          mem_req_ready_i,
   output logic [TAG_WIDHT+TAG_ADDR_WIDHT-1:0] mem_req_addr_o,
   input  logic                          mem_rsp_valid_i,
   input  logic                          mem_rsp_err_i,
   output logic                          tag_req_o,
   output logic                          tag_we_o,
   output logic [NUM_WAYS-1:0]           tag_way_o,
   output logic [TAG_ADDR_WIDHT-1:0]     tag_addr_o,
   output logic [TAG_WIDHT-1:0]          tag_data_o,
   output logic                          tag_vbit_o,
   output logic                          refill_done_o
);

   refill_state_e               state_q, state_d;
   logic [TAG_WIDHT-1:0]        tag_q, tag_d;
   logic [TAG_ADDR_WIDHT-1:0]   idx_q, idx_d;
   logic [NUM_WAYS-1:0]         way_q, way_d;
   logic                        err_q, err_d;
   logic [NUM_WAYS-1:0]         victim;
   logic                        write_fire;
   logic                        in_req;

   assign write_fire = (state_q == ST_WRITE) && !flush_i;
   assign in_req     = (state_q == ST_REQ);

   sargantana_icache_victim_sel #(
      .NUM_WAYS (NUM_WAYS)
   ) u_victim_sel (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .vbits_i   (set_vbits_i),
      .advance_i (write_fire),
      .victim_o  (victim)
   );

   always_comb begin
      state_d = state_q;
      tag_d   = tag_q;
      idx_d   = idx_q;
      way_d   = way_q;
      err_d   = err_q;
      unique case (state_q)
         ST_IDLE: begin
            if (miss_i && !flush_i) begin
               tag_d   = miss_tag_i;
               idx_d   = miss_idx_i;
               way_d   = victim;
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            if (flush_i)              state_d = ST_IDLE;
            else if (mem_req_ready_i) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            // A flush coinciding with the response has nothing left to drain.
            if (flush_i) begin
               state_d = mem_rsp_valid_i ? ST_IDLE : ST_DRAIN;
            end else if (mem_rsp_valid_i) begin
               err_d   = mem_rsp_err_i;
               state_d = ST_WRITE;
            end
         end
         ST_WRITE: state_d = ST_IDLE;
         ST_DRAIN: begin
            if (mem_rsp_valid_i) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Request payload needs no reset: every output using it is gated by state.
   always_ff @(posedge clk_i) begin
      tag_q <= tag_d;
      idx_q <= idx_d;
      way_q <= way_d;
      err_q <= err_d;
   end

   assign busy_o          = (state_q != ST_IDLE);
   assign mem_req_valid_o = in_req && !flush_i;
   assign mem_req_addr_o  = in_req ? {tag_q, idx_q} : '0;
   assign tag_req_o       = write_fire;
   assign tag_we_o        = write_fire;
   assign tag_way_o       = write_fire ? way_q : '0;
   assign tag_addr_o      = write_fire ? idx_q : '0;
   assign tag_data_o      = write_fire ? tag_q : '0;
   assign tag_vbit_o      = write_fire && !err_q;
   assign refill_done_o   = write_fire;

endmodule

// File: tb/tb_sargantana_icache_refill_ctrl.sv
// Scoreboard bench for sargantana_icache_refill_ctrl (default 4 ways, 20-bit tag, 64 sets).
module tb_sargantana_icache_refill_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        miss = 1'b0;
   logic [19:0] miss_tag = '0;
   logic [5:0]  miss_idx = '0;
   logic [3:0]  vbits = '0;
   logic        flush = 1'b0;
   logic        busy;
   logic        mem_req_valid;
   logic        mem_req_ready = 1'b0;
   logic [25:0] mem_req_addr;
   logic        mem_rsp_valid = 1'b0;
   logic        mem_rsp_err = 1'b0;
   logic        tag_req;
   logic        tag_we;
   logic [3:0]  tag_way;
   logic [5:0]  tag_addr;
   logic [19:0] tag_data;
   logic        tag_vbit;
   logic        refill_done;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [3:0]  way;
      logic [5:0]  idx;
      logic [19:0] tag;
      logic        vbit;
   } exp_t;

   exp_t exp_q[$];

   int unsigned model_rr   = 0;
   logic [7:0]  model_lfsr = 8'h01;

   always #5 clk = ~clk;

   sargantana_icache_refill_ctrl dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .miss_i          (miss),
      .miss_tag_i      (miss_tag),
      .miss_idx_i      (miss_idx),
      .set_vbits_i     (vbits),
      .flush_i         (flush),
      .busy_o          (busy),
      .mem_req_valid_o (mem_req_valid),
      .mem_req_ready_i (mem_req_ready),
      .mem_req_addr_o  (mem_req_addr),
      .mem_rsp_valid_i (mem_rsp_valid),
      .mem_rsp_err_i   (mem_rsp_err),
      .tag_req_o       (tag_req),
      .tag_we_o        (tag_we),
      .tag_way_o       (tag_way),
      .tag_addr_o      (tag_addr),
      .tag_data_o      (tag_data),
      .tag_vbit_o      (tag_vbit),
      .refill_done_o   (refill_done)
   );

   function automatic logic [3:0] model_victim(input logic [3:0] vb);
      for (int i = 0; i < 4; i++) if (!vb[i]) return 4'b0001 << i;
`ifdef SARGANTANA_ICACHE_LFSR_REPL_EN
      return 4'b0001 << model_lfsr[1:0];
`else
      return 4'b0001 << model_rr[1:0];
`endif
   endfunction

   task automatic model_advance();
      model_rr   = model_rr + 1;
      model_lfsr = {model_lfsr[6:0], model_lfsr[7] ^ model_lfsr[5] ^ model_lfsr[4] ^ model_lfsr[3]};
   endtask

   task automatic model_reset();
      model_rr   = 0;
      model_lfsr = 8'h01;
   endtask

   // Every tag write must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (tag_req === 1'b1) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_tag_write: way=%b addr=%0d data=%h vbit=%b, required no write",
                     tag_way, tag_addr, tag_data, tag_vbit);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if ({tag_we, tag_way, tag_addr, tag_data, tag_vbit} !== {1'b1, e.way, e.idx, e.tag, e.vbit}) begin
               bad++;
               $display("FAIL tag_write: we=%b way=%b addr=%0d data=%h vbit=%b, required we=1 way=%b addr=%0d data=%h vbit=%b",
                        tag_we, tag_way, tag_addr, tag_data, tag_vbit, e.way, e.idx, e.tag, e.vbit);
            end
         end
      end
   end

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
   endtask

   task automatic run_refill(input logic [19:0] t, input logic [5:0] ix, input logic [3:0] vb,
                             input logic [3:0] way, input int rdy_dly, input int rsp_dly,
                             input logic err, input string nm);
      exp_t e;
      e.way = way; e.idx = ix; e.tag = t; e.vbit = !err;
      exp_q.push_back(e);
      @(posedge clk); #1;
      miss = 1'b1; miss_tag = t; miss_idx = ix; vbits = vb;
      @(posedge clk); #1;
      // Requester keeps miss high while busy; changed payload must not be taken.
      miss_tag = ~t; miss_idx = ~ix;
      total++;
      if (busy !== 1'b1 || mem_req_valid !== 1'b1 || mem_req_addr !== {t, ix}) begin
         bad++;
         $display("FAIL %s_req: busy=%b valid=%b addr=%h, required busy=1 valid=1 addr=%h",
                  nm, busy, mem_req_valid, mem_req_addr, {t, ix});
      end
      for (int k = 0; k < rdy_dly; k++) begin
         @(posedge clk); #1;
         total++;
         if (mem_req_valid !== 1'b1 || mem_req_addr !== {t, ix}) begin
            bad++;
            $display("FAIL %s_req_hold: valid=%b addr=%h, required valid=1 addr=%h",
                     nm, mem_req_valid, mem_req_addr, {t, ix});
         end
      end
      mem_req_ready = 1'b1;
      @(posedge clk); #1;
      mem_req_ready = 1'b0;
      total++;
      if (mem_req_valid !== 1'b0 || busy !== 1'b1) begin
         bad++;
         $display("FAIL %s_wait: valid=%b busy=%b, required valid=0 busy=1", nm, mem_req_valid, busy);
      end
      for (int k = 0; k < rsp_dly - 1; k++) begin
         @(posedge clk); #1;
      end
      miss = 1'b0;
      mem_rsp_valid = 1'b1; mem_rsp_err = err;
      @(posedge clk); #1;
      mem_rsp_valid = 1'b0; mem_rsp_err = 1'b0;
      total++;
      if (refill_done !== 1'b1 || busy !== 1'b1 || tag_vbit !== !err) begin
         bad++;
         $display("FAIL %s_done: done=%b busy=%b vbit=%b, required done=1 busy=1 vbit=%b",
                  nm, refill_done, busy, tag_vbit, !err);
      end
      model_advance();
      @(posedge clk); #1;
      total++;
      if (refill_done !== 1'b0 || busy !== 1'b0 || tag_req !== 1'b0) begin
         bad++;
         $display("FAIL %s_after: done=%b busy=%b tag_req=%b, required all 0", nm, refill_done, busy, tag_req);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if ({busy, mem_req_valid, tag_req, tag_we, tag_vbit, refill_done} !== 6'b0) begin
         bad++;
         $display("FAIL reset_ctrl: busy=%b valid=%b req=%b we=%b vbit=%b done=%b, required all 0",
                  busy, mem_req_valid, tag_req, tag_we, tag_vbit, refill_done);
      end
      total++;
      if (tag_way !== 4'b0 || tag_addr !== 6'b0 || tag_data !== 20'b0 || mem_req_addr !== 26'b0) begin
         bad++;
         $display("FAIL reset_data: way=%b addr=%0d data=%h maddr=%h, required all 0",
                  tag_way, tag_addr, tag_data, mem_req_addr);
      end
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_basic();
      run_refill(20'hABCDE, 6'd5, 4'b1011, 4'b0100, 0, 3, 1'b0, "basic");
   endtask

   task automatic test_replacement();
      logic [3:0] rr_ways [3];
      logic [3:0] w;
      rr_ways[0] = 4'b0001; rr_ways[1] = 4'b0010; rr_ways[2] = 4'b0100;
      do_reset();
      for (int i = 0; i < 3; i++) begin
`ifdef SARGANTANA_ICACHE_LFSR_REPL_EN
         w = model_victim(4'b1111);
`else
         w = rr_ways[i];
`endif
         run_refill(20'h10000 + 20'(i), 6'(i + 10), 4'b1111, w, 1, 2, 1'b0, "repl");
      end
   endtask

   task automatic test_error();
      run_refill(20'h5A5A5, 6'd63, 4'b0000, 4'b0001, 2, 1, 1'b1, "error");
   endtask

   task automatic test_back_to_back();
      run_refill(20'h00001, 6'd0, 4'b0111, 4'b1000, 0, 1, 1'b0, "b2b_a");
      run_refill(20'hFFFFF, 6'd33, 4'b1101, 4'b0010, 0, 1, 1'b0, "b2b_b");
   endtask

   task automatic test_flush_idle_req();
      @(posedge clk); #1;
      miss = 1'b1; miss_tag = 20'h12345; miss_idx = 6'd7; vbits = 4'b1111; flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL flush_idle: busy=%b, required 0", busy);
      end
      @(posedge clk); #1;
      miss = 1'b0;
      total++;
      if (busy !== 1'b1 || mem_req_addr !== {20'h12345, 6'd7}) begin
         bad++;
         $display("FAIL flush_idle_accept: busy=%b addr=%h, required busy=1 addr=%h",
                  busy, mem_req_addr, {20'h12345, 6'd7});
      end
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      total++;
      if (busy !== 1'b0 || mem_req_valid !== 1'b0 || refill_done !== 1'b0) begin
         bad++;
         $display("FAIL flush_req: busy=%b valid=%b done=%b, required all 0", busy, mem_req_valid, refill_done);
      end
   endtask

   task automatic test_flush_wait();
      @(posedge clk); #1;
      miss = 1'b1; miss_tag = 20'h0BEEF; miss_idx = 6'd12; vbits = 4'b0000;
      @(posedge clk); #1;
      miss = 1'b0; mem_req_ready = 1'b1;
      @(posedge clk); #1;
      mem_req_ready = 1'b0; flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      total++;
      if (busy !== 1'b1 || refill_done !== 1'b0) begin
         bad++;
         $display("FAIL flush_drain: busy=%b done=%b, required busy=1 done=0", busy, refill_done);
      end
      @(posedge clk); #1;
      mem_rsp_valid = 1'b1;
      @(posedge clk); #1;
      mem_rsp_valid = 1'b0;
      total++;
      if (busy !== 1'b0 || refill_done !== 1'b0 || tag_req !== 1'b0) begin
         bad++;
         $display("FAIL flush_wait_end: busy=%b done=%b tag_req=%b, required all 0", busy, refill_done, tag_req);
      end
   endtask

   task automatic test_reset_mid_req();
      @(posedge clk); #1;
      miss = 1'b1; miss_tag = 20'hC0FFE; miss_idx = 6'd40; vbits = 4'b1111;
      @(posedge clk); #1;
      miss = 1'b0;
      for (int k = 0; k < 5; k++) begin
         total++;
         if (mem_req_valid !== 1'b1 || mem_req_addr !== {20'hC0FFE, 6'd40}) begin
            bad++;
            $display("FAIL rst_req_hold: cycle=%0d valid=%b addr=%h, required valid=1 addr=%h",
                     k, mem_req_valid, mem_req_addr, {20'hC0FFE, 6'd40});
         end
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      total++;
      if ({busy, mem_req_valid, tag_req, tag_we, tag_vbit, refill_done} !== 6'b0 ||
          mem_req_addr !== 26'b0 || tag_way !== 4'b0) begin
         bad++;
         $display("FAIL rst_mid_req: busy=%b valid=%b maddr=%h way=%b, required all 0",
                  busy, mem_req_valid, mem_req_addr, tag_way);
      end
      mem_rsp_valid = 1'b1;
      @(posedge clk); #1;
      mem_rsp_valid = 1'b0;
      total++;
      if (busy !== 1'b0 || refill_done !== 1'b0 || tag_req !== 1'b0) begin
         bad++;
         $display("FAIL rst_stale_rsp: busy=%b done=%b tag_req=%b, required all 0", busy, refill_done, tag_req);
      end
      // Replacement state is back at its seed after reset.
`ifdef SARGANTANA_ICACHE_LFSR_REPL_EN
      run_refill(20'h77777, 6'd1, 4'b1111, 4'b0010, 0, 1, 1'b0, "post_rst");
`else
      run_refill(20'h77777, 6'd1, 4'b1111, 4'b0001, 0, 1, 1'b0, "post_rst");
`endif
   endtask

   initial begin
      test_reset();
      test_basic();
      test_replacement();
      test_error();
      test_back_to_back();
      test_flush_idle_req();
      test_flush_wait();
      test_reset_mid_req();
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain: outstanding=%0d, required 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
